sif_xa_responder: RTL and testbench
===================================

SIF_XA_RESPONDER -- requirements
Module: sif_xa_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning the register-file address width (16 entries).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the data width.
REQ-003 SHALL have parameter RD_LAT, default 2, legal range 1..8, meaning the cycles from read-strobe sample to read data.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port xa_wr_st, input, 1, the write strobe from the initiator.
REQ-007 SHALL have port xa_rd_st, input, 1, the read strobe from the initiator.
REQ-008 SHALL have port xa_addr, input, ADDR_W, the target address, sampled with the strobes.
REQ-009 SHALL have port xa_wdata, input, DATA_W, the write data, sampled with xa_wr_st.
REQ-010 SHALL have port xa_rdata, output, DATA_W, the read data, valid only while xa_rd_vld=1.
REQ-011 SHALL have port xa_rd_vld, output, 1, a single-cycle read-response pulse.
REQ-012 SHALL have port xa_busy, output, 1; while it is high, strobes are ignored.
REQ-013 SHALL have port xa_err, output, 1, a single-cycle illegal-operation pulse.

Function
REQ-014 SHALL implement FSM states IDLE, WR, RD_WAIT and RD_RESP; strobes SHALL be sampled only in IDLE.
REQ-015 The strobe code {rst_n,xa_wr_st,xa_rd_st} SHALL decode as 110=WRITE, 101=READ, 100=IDLE and 111=ILLEGAL.
REQ-016 WRITE sampled at edge N SHALL update mem[xa_addr] at edge N and enter WR; xa_busy SHALL be 1 for cycle N+1 only, then the FSM SHALL return to IDLE.
REQ-017 READ sampled at edge N SHALL latch the address, enter RD_WAIT and load a down-counter with RD_LAT-1.
REQ-018 xa_busy SHALL be 1 from cycle N+1 through N+RD_LAT inclusive.
REQ-019 The RD_WAIT-to-RD_RESP transition SHALL occur when the counter reaches 0; with RD_LAT=1 the FSM SHALL go directly to RD_RESP.
REQ-020 In RD_RESP (cycle N+RD_LAT), xa_rd_vld SHALL be 1 and xa_rdata SHALL equal mem[latched addr] as of that cycle; the FSM SHALL then return to IDLE.
REQ-021 xa_rdata SHALL be all-zero whenever xa_rd_vld=0.
REQ-022 An ILLEGAL code sampled in IDLE SHALL pulse xa_err for exactly one cycle (N+1), leave memory unchanged and keep the FSM in IDLE, with xa_busy=0.
REQ-023 Back-to-back ops SHALL be supported: a strobe presented in the first cycle after return to IDLE SHALL be accepted.
REQ-024 Strobes, including ILLEGAL, presented while xa_busy=1 SHALL be ignored with no memory change, no xa_err and no queuing.
REQ-025 A write followed by a read of the same address SHALL return the new data.
REQ-026 Address wrap-around SHALL NOT exist: every address 0..2^ADDR_W-1 SHALL be a distinct entry.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the FSM to IDLE, the counter to 0, all memory entries to 0, and xa_rdata=0, xa_rd_vld=0, xa_busy=0, xa_err=0.
REQ-028 Reset asserted mid-read SHALL abort the read, and no xa_rd_vld SHALL follow the release of reset.
REQ-029 Reset asserted mid-write cycle SHALL leave the target entry at 0.
REQ-030 The first strobe SHALL be sampled at the first rising edge with rst_n=1.

Configuration
REQ-031 Macro SIF_XA_ILL_CNT_EN, when defined, SHALL add an 8-bit saturating (holds at 255) illegal-operation counter that increments on each accepted ILLEGAL code.
REQ-032 With SIF_XA_ILL_CNT_EN defined, address 2^ADDR_W-1 SHALL read the counter (zero-extended to DATA_W) instead of storage.
REQ-033 With SIF_XA_ILL_CNT_EN defined, a write to address 2^ADDR_W-1 SHALL clear the counter regardless of data.
REQ-034 With SIF_XA_ILL_CNT_EN defined, the counter SHALL reset to 0.
REQ-035 Without SIF_XA_ILL_CNT_EN, no counter logic SHALL exist and address 2^ADDR_W-1 SHALL be ordinary storage.

Verification
REQ-036 Bench SHALL cover: reset release, write 0xA5 @3, read @3 (RD_LAT=2) -> xa_rd_vld pulses 2 cycles after the read sample, xa_rdata=0xA5, xa_busy high exactly 2 cycles.
REQ-037 Bench SHALL cover: wr_st=rd_st=1 @5 in IDLE -> xa_err=1 for one cycle, xa_busy=0, a subsequent read @5 returns 0x00.
REQ-038 Bench SHALL cover: write 0x3C @7, then write 0xFF @7 during the busy cycle -> the second write is ignored and read @7 returns 0x3C.
REQ-039 Bench SHALL cover: read @2 then rst_n=0 in RD_WAIT -> no xa_rd_vld after release, and read @2 returns 0x00.
REQ-040 Bench SHALL cover: with RD_LAT=1, back-to-back write 0x11 @0 and read @0 -> xa_rd_vld one cycle after the read sample with 0x11.
REQ-041 Bench SHALL cover, with SIF_XA_ILL_CNT_EN: 3 illegal ops then read @15 -> 0x03; write @15 then read @15 -> 0x00; 300 illegal ops then read @15 -> 0xFF.

Source files
------------

// File: rtl/sif_xa_responder.sv
// Strobe-driven register-file responder: single-cycle writes, fixed-latency reads, illegal-code flagging.
// Optional macro SIF_XA_ILL_CNT_EN maps a saturating illegal-operation counter onto the top address.
module sif_xa_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              xa_wr_st,
    input  logic              xa_rd_st,
    input  logic [ADDR_W-1:0] xa_addr,
    input  logic [DATA_W-1:0] xa_wdata,
    output logic [DATA_W-1:0] xa_rdata,
    output logic              xa_rd_vld,
    output logic              xa_busy,
    output logic              xa_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_val_s;
    logic              wr_en_s;
    logic              wr_mem_s;
    logic              ill_s;
    logic [DATA_W-1:0] rdata_r;
    logic              rd_vld_r;
    logic              busy_r;
    logic              err_r;

`ifdef SIF_XA_ILL_CNT_EN
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    logic [7:0] ill_cnt_r;
    logic       cnt_clr_s;
`endif

    // Next-state decode; strobes are only looked at while idle
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        wr_en_s = 1'b0;
        ill_s   = 1'b0;
        case (state_r)
            IDLE: begin
                case ({xa_wr_st, xa_rd_st})
                    2'b10: begin
                        wr_en_s = 1'b1;
                        state_s = WR;
                    end
                    2'b01: begin
                        addr_s = xa_addr;
                        if (RD_LAT == 1) begin
                            cnt_s   = '0;
                            state_s = RD_RESP;
                        end else begin
                            cnt_s   = CNT_INIT;
                            state_s = RD_WAIT;
                        end
                    end
                    2'b11: begin
                        ill_s = 1'b1;
                    end
                    default: begin
                        state_s = IDLE;
                    end
                endcase
            end
            WR: begin
                state_s = IDLE;
            end
            RD_WAIT: begin
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_s   = '0;
                    state_s = RD_RESP;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            RD_RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Read source and write routing; the top address is diverted to the counter when enabled
    always_comb begin
        rd_val_s = mem_r[addr_s];
        wr_mem_s = wr_en_s;
`ifdef SIF_XA_ILL_CNT_EN
        cnt_clr_s = wr_en_s && (xa_addr == ADDR_MAX);
        if (addr_s == ADDR_MAX) begin
            rd_val_s = DATA_W'(ill_cnt_r);
        end else begin
            rd_val_s = mem_r[addr_s];
        end
        if (xa_addr == ADDR_MAX) begin
            wr_mem_s = 1'b0;
        end else begin
            wr_mem_s = wr_en_s;
        end
`endif
    end

    // FSM state, latency counter and latched read address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            addr_r  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
        end
    end

    // Register file storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_mem_s) begin
            mem_r[xa_addr] <= xa_wdata;
        end
    end

`ifdef SIF_XA_ILL_CNT_EN
    // Saturating illegal-operation counter, cleared by any write to the top address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_r <= 8'd0;
        end else if (cnt_clr_s) begin
            ill_cnt_r <= 8'd0;
        end else if (ill_s && (ill_cnt_r != 8'hFF)) begin
            ill_cnt_r <= ill_cnt_r + 8'd1;
        end
    end
`endif

    // Registered outputs derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r  <= '0;
            rd_vld_r <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            rdata_r  <= (state_s == RD_RESP) ? rd_val_s : '0;
            rd_vld_r <= (state_s == RD_RESP);
            busy_r   <= (state_s != IDLE);
            err_r    <= ill_s;
        end
    end

    assign xa_rdata  = rdata_r;
    assign xa_rd_vld = rd_vld_r;
    assign xa_busy   = busy_r;
    assign xa_err    = err_r;

endmodule

// File: tb/tb_sif_xa_responder.sv
// Randomized + directed bench for sif_xa_responder; two instances (RD_LAT=2 and RD_LAT=1) share stimulus.
// Build with SIF_XA_ILL_CNT_EN defined to exercise the illegal-operation counter.
module tb_sif_xa_responder;

    localparam int NC = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_st;
    logic       rd_st;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata0, rdata1;
    logic       vld0, vld1, busy0, busy1, err0, err1;

    always #5 clk = ~clk;

    sif_xa_responder #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .xa_wr_st(wr_st), .xa_rd_st(rd_st),
        .xa_addr(addr), .xa_wdata(wdata), .xa_rdata(rdata0),
        .xa_rd_vld(vld0), .xa_busy(busy0), .xa_err(err0)
    );

    sif_xa_responder #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .xa_wr_st(wr_st), .xa_rd_st(rd_st),
        .xa_addr(addr), .xa_wdata(wdata), .xa_rdata(rdata1),
        .xa_rd_vld(vld1), .xa_busy(busy1), .xa_err(err1)
    );

    // Transaction-level model: storage, counter, edge until which each DUT is busy,
    // and per-cycle expected outputs (ring indexed by cycle number)
    logic [7:0] mem_m [2][16];
    int         ill_m [2];
    int         busy_end [2];
    bit         e_vld  [2][NC];
    bit         e_busy [2][NC];
    bit         e_err  [2][NC];
    logic [7:0] e_data [2][NC];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    int         vld_idx [2];
    logic [7:0] vld_data [2];
    int         vld_cnt [2];
    int         busy_cnt [2];
    int         err_cnt [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, d, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input int d, input int a);
        logic [31:0] c;
        c = ill_m[d];
`ifdef SIF_XA_ILL_CNT_EN
        if (a == 15) return c[7:0];
`endif
        return mem_m[d][a];
    endfunction

    // Apply the inputs that the upcoming edge e will sample
    task automatic model_apply(input int e);
        int L;
        for (int d = 0; d < 2; d++) begin
            L = lat_of(d);
            if (rst_n !== 1'b1) continue;
            if (e <= busy_end[d]) continue;
            if (wr_st && rd_st) begin
                e_err[d][(e + 1) % NC] = 1'b1;
                if (ill_m[d] < 255) ill_m[d]++;
            end else if (wr_st) begin
`ifdef SIF_XA_ILL_CNT_EN
                if (addr == 4'hF) ill_m[d] = 0;
                else mem_m[d][addr] = wdata;
`else
                mem_m[d][addr] = wdata;
`endif
                e_busy[d][(e + 1) % NC] = 1'b1;
                busy_end[d] = e + 1;
            end else if (rd_st) begin
                for (int k = 1; k <= L; k++) e_busy[d][(e + k) % NC] = 1'b1;
                e_vld[d][(e + L) % NC]  = 1'b1;
                e_data[d][(e + L) % NC] = model_rd(d, int'(addr));
                busy_end[d] = e + L;
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 16; a++) mem_m[d][a] = 8'h00;
            ill_m[d] = 0;
            busy_end[d] = cyc;
            for (int i = 0; i < NC; i++) begin
                e_vld[d][i] = 1'b0;
                e_busy[d][i] = 1'b0;
                e_err[d][i] = 1'b0;
                e_data[d][i] = 8'h00;
            end
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [3:0] a, input logic [7:0] wd);
        wr_st = w;
        rd_st = r;
        addr  = a;
        wdata = wd;
        model_apply(cyc + 1);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic rst_pulse(input int n);
        rst_n = 1'b0;
        model_reset();
        idle(n);
        rst_n = 1'b1;
    endtask

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            vld_cnt[d] = 0;
            busy_cnt[d] = 0;
            err_cnt[d] = 0;
            vld_idx[d] = -100;
        end
    endtask

    // Compare process: every cycle, both DUTs against the model
    always @(negedge clk) begin
        int         i;
        logic [7:0] a_rdata;
        logic       a_vld, a_busy, a_err;
        i = (cyc + 1) % NC;
        for (int d = 0; d < 2; d++) begin
            a_rdata = (d == 0) ? rdata0 : rdata1;
            a_vld   = (d == 0) ? vld0   : vld1;
            a_busy  = (d == 0) ? busy0  : busy1;
            a_err   = (d == 0) ? err0   : err1;
            chk("rd_vld", d, 32'(a_vld), 32'(e_vld[d][i]));
            chk("rdata", d, 32'(a_rdata), e_vld[d][i] ? 32'(e_data[d][i]) : 32'h0);
            chk("busy", d, 32'(a_busy), 32'(e_busy[d][i]));
            chk("err", d, 32'(a_err), 32'(e_err[d][i]));
            if (a_vld === 1'b1) begin
                vld_idx[d] = cyc + 1;
                vld_data[d] = a_rdata;
                vld_cnt[d]++;
            end
            if (a_busy === 1'b1) busy_cnt[d]++;
            if (a_err === 1'b1) err_cnt[d]++;
            e_vld[d][i] = 1'b0;
            e_busy[d][i] = 1'b0;
            e_err[d][i] = 1'b0;
            e_data[d][i] = 8'h00;
        end
    end

    initial begin
        int rs;
        int op;
        rst_n = 1'b1;
        wr_st = 1'b0;
        rd_st = 1'b0;
        addr  = 4'h0;
        wdata = 8'h00;
        clr_stats();
        #1;
        rst_pulse(3);
        idle(2);

        // write 0xA5 @3, read @3
        step(1'b1, 1'b0, 4'h3, 8'hA5);
        idle(3);
        clr_stats();
        rs = cyc + 1;
        step(1'b0, 1'b1, 4'h3, 8'h00);
        idle(4);
        chk("lat2_delay", 0, 32'(vld_idx[0] - rs), 32'd2);
        chk("lat2_data", 0, 32'(vld_data[0]), 32'hA5);
        chk("lat2_busy_len", 0, 32'(busy_cnt[0]), 32'd2);
        chk("lat2_vld_pulses", 0, 32'(vld_cnt[0]), 32'd1);
        chk("lat1_delay", 1, 32'(vld_idx[1] - rs), 32'd1);

        // illegal @5, then read @5
        clr_stats();
        step(1'b1, 1'b1, 4'h5, 8'h77);
        idle(2);
        chk("ill_err_pulses", 0, 32'(err_cnt[0]), 32'd1);
        chk("ill_busy", 0, 32'(busy_cnt[0]), 32'd0);
        step(1'b0, 1'b1, 4'h5, 8'h00);
        idle(4);
        chk("ill_read5", 0, 32'(vld_data[0]), 32'h00);

        // write 0x3C @7, second write during busy ignored
        step(1'b1, 1'b0, 4'h7, 8'h3C);
        step(1'b1, 1'b0, 4'h7, 8'hFF);
        idle(3);
        step(1'b0, 1'b1, 4'h7, 8'h00);
        idle(4);
        chk("busy_wr_ignored", 0, 32'(vld_data[0]), 32'h3C);
        chk("busy_wr_ignored", 1, 32'(vld_data[1]), 32'h3C);
        chk("model_pin_7", 0, 32'(model_rd(0, 7)), 32'h3C);

        // read @2, reset while waiting
        step(1'b1, 1'b0, 4'h2, 8'h5A);
        idle(3);
        step(1'b0, 1'b1, 4'h2, 8'h00);
        clr_stats();
        rst_pulse(2);
        idle(4);
        chk("no_vld_after_rst", 0, 32'(vld_cnt[0]), 32'd0);
        step(1'b0, 1'b1, 4'h2, 8'h00);
        idle(4);
        chk("read2_after_rst", 0, 32'(vld_data[0]), 32'h00);
        chk("read2_vld_pulses", 0, 32'(vld_cnt[0]), 32'd1);

        // back-to-back write 0x11 @0 then read @0
        step(1'b1, 1'b0, 4'h0, 8'h11);
        idle(1);
        clr_stats();
        rs = cyc + 1;
        step(1'b0, 1'b1, 4'h0, 8'h00);
        idle(3);
        chk("b2b_lat1_delay", 1, 32'(vld_idx[1] - rs), 32'd1);
        chk("b2b_lat1_data", 1, 32'(vld_data[1]), 32'h11);
        chk("b2b_lat2_data", 0, 32'(vld_data[0]), 32'h11);

`ifdef SIF_XA_ILL_CNT_EN
        step(1'b1, 1'b0, 4'hF, 8'h99);
        idle(1);
        repeat (3) step(1'b1, 1'b1, 4'h1, 8'h00);
        idle(1);
        step(1'b0, 1'b1, 4'hF, 8'h00);
        idle(4);
        chk("ill_cnt_3", 0, 32'(vld_data[0]), 32'h03);
        step(1'b1, 1'b0, 4'hF, 8'h42);
        idle(2);
        step(1'b0, 1'b1, 4'hF, 8'h00);
        idle(4);
        chk("ill_cnt_clr", 0, 32'(vld_data[0]), 32'h00);
        repeat (300) step(1'b1, 1'b1, 4'h9, 8'h00);
        idle(1);
        step(1'b0, 1'b1, 4'hF, 8'h00);
        idle(4);
        chk("ill_cnt_sat", 0, 32'(vld_data[0]), 32'hFF);
        chk("ill_cnt_sat", 1, 32'(vld_data[1]), 32'hFF);
`else
        step(1'b1, 1'b0, 4'hF, 8'h42);
        idle(2);
        step(1'b0, 1'b1, 4'hF, 8'h00);
        idle(4);
        chk("top_addr_storage", 0, 32'(vld_data[0]), 32'h42);
`endif

        // randomized traffic
        repeat (1500) begin
            op = $urandom_range(0, 99);
            if (op < 2) begin
                rst_pulse($urandom_range(1, 2));
            end else if (op < 32) begin
                step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end else if (op < 62) begin
                step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end else if (op < 72) begin
                step(1'b1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            end else begin
                idle(1);
            end
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
